// File: rtl/softmax_normalizer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : softmax_normalizer
// Purpose  : Final softmax stage. For every subgraph one {num_node, sum} entry
//            is popped from the divisor FIFO, then num_node exp-values are
//            popped from the dividend FIFO. Each exp-value is divided by the
//            sum with a bit-serial restoring divider and the unsigned Q1.31
//            alpha coefficient is pushed into the alpha FIFO.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            divisor_ff_*                - {num_node, sum} FIFO read side
//            dividend_ff_*               - exp-value FIFO read side
//            alpha_ff_*                  - alpha FIFO write side
//            sm_done_o                   - 1-cycle pulse, subgraph finished
// Revision : 1.0 - initial release
// ============================================================================
module softmax_normalizer #(
   parameter int SM_DATA_WIDTH     = 108,
   parameter int SM_SUM_DATA_WIDTH = 108,
   parameter int ALPHA_DATA_WIDTH  = 32,
   parameter int MAX_NODES         = 168,
   parameter int NUM_NODE_WIDTH    = $clog2(MAX_NODES)
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [NUM_NODE_WIDTH+SM_SUM_DATA_WIDTH-1:0] divisor_ff_dout,
   input  logic                                      divisor_ff_empty,
   output logic                                      divisor_ff_rd_vld,
   input  logic [SM_DATA_WIDTH-1:0]                  dividend_ff_dout,
   input  logic                                      dividend_ff_empty,
   output logic                                      dividend_ff_rd_vld,
   output logic [ALPHA_DATA_WIDTH-1:0]               alpha_ff_din,
   input  logic                                      alpha_ff_full,
   output logic                                      alpha_ff_wr_vld,
   output logic                                      sm_done_o
);

   localparam int WOF   = ALPHA_DATA_WIDTH - 1;
   localparam int BIT_W = (WOF > 1) ? $clog2(WOF) : 1;
   // Common width for the dividend >= sum test, wide enough for either operand.
   localparam int CMP_W = ((SM_DATA_WIDTH > SM_SUM_DATA_WIDTH) ?
                           SM_DATA_WIDTH : SM_SUM_DATA_WIDTH) + 1;
   localparam logic [ALPHA_DATA_WIDTH-1:0] ALPHA_SAT = {1'b0, {WOF{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD_SUM = 3'd1,
      S_FETCH    = 3'd2,
      S_LATCH    = 3'd3,
      S_DIV      = 3'd4,
      S_PUSH     = 3'd5
   } state_t;

   state_t                              state_q;
   logic [NUM_NODE_WIDTH-1:0]           num_node_q;
   logic [NUM_NODE_WIDTH-1:0]           cnt_q;
   logic [SM_SUM_DATA_WIDTH-1:0]        sum_q;
   logic [SM_SUM_DATA_WIDTH:0]          rem_q;
   logic [ALPHA_DATA_WIDTH-1:0]         quot_q;
   logic [ALPHA_DATA_WIDTH-1:0]         alpha_q;
   logic [BIT_W-1:0]                    bit_q;

   logic [NUM_NODE_WIDTH-1:0]           w_num_in;
   logic [SM_SUM_DATA_WIDTH-1:0]        w_sum_in;
   logic [CMP_W-1:0]                    w_dvd_ext;
   logic [CMP_W-1:0]                    w_sum_ext;
   logic [SM_SUM_DATA_WIDTH+1:0]        w_shift;
   logic [SM_SUM_DATA_WIDTH+1:0]        w_sum_sh;
   logic                                w_ge;
   logic                                w_last;
   logic [ALPHA_DATA_WIDTH-1:0]         w_quot_upd;

   assign w_num_in  = divisor_ff_dout[NUM_NODE_WIDTH+SM_SUM_DATA_WIDTH-1 -: NUM_NODE_WIDTH];
   assign w_sum_in  = divisor_ff_dout[SM_SUM_DATA_WIDTH-1:0];
   assign w_dvd_ext = CMP_W'(dividend_ff_dout);
   assign w_sum_ext = CMP_W'(sum_q);

   // Partial remainder doubled; one extra bit keeps the shift lossless.
   assign w_shift  = {rem_q, 1'b0};
   assign w_sum_sh = {2'b00, sum_q};
   assign w_ge     = (w_shift >= w_sum_sh);

   // cnt_q counts pushes already made, so the current push is the last one
   // when cnt_q+1 reaches num_node.
   assign w_last = ((cnt_q + 1'b1) == num_node_q);

   always_comb begin
      w_quot_upd = quot_q;
      if (w_ge) begin
         w_quot_upd[bit_q] = 1'b1;
      end
   end

   // FIFO strobes depend on the live empty/full flags, so they are decoded
   // combinationally from the registered state. The divisor pop is also
   // qualified with rst_n because IDLE is the reset state.
   assign divisor_ff_rd_vld  = rst_n && (state_q == S_IDLE) && !divisor_ff_empty;
   assign dividend_ff_rd_vld = (state_q == S_FETCH) && !dividend_ff_empty;
   assign alpha_ff_wr_vld    = (state_q == S_PUSH) && !alpha_ff_full;
   assign alpha_ff_din       = alpha_q;
   assign sm_done_o          = ((state_q == S_LOAD_SUM) && (w_num_in == '0)) ||
                               (alpha_ff_wr_vld && w_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         num_node_q <= '0;
         cnt_q      <= '0;
         sum_q      <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         alpha_q    <= '0;
         bit_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (divisor_ff_rd_vld) begin
                  state_q <= S_LOAD_SUM;
               end
            end

            // divisor_ff_dout is valid this cycle (one cycle after the pop).
            S_LOAD_SUM: begin
               num_node_q <= w_num_in;
               sum_q      <= w_sum_in;
               cnt_q      <= '0;
               state_q    <= (w_num_in == '0) ? S_IDLE : S_FETCH;
            end

            S_FETCH: begin
               if (dividend_ff_rd_vld) begin
                  state_q <= S_LATCH;
               end
            end

            // dividend_ff_dout is valid this cycle. A zero sum or a dividend
            // not below the sum skips the divider entirely.
            S_LATCH: begin
               rem_q  <= w_dvd_ext[SM_SUM_DATA_WIDTH:0];
               quot_q <= '0;
               bit_q  <= BIT_W'(WOF - 1);
               if (sum_q == '0) begin
                  alpha_q <= '0;
                  state_q <= S_PUSH;
               end else if (w_dvd_ext >= w_sum_ext) begin
                  alpha_q <= ALPHA_SAT;
                  state_q <= S_PUSH;
               end else begin
                  state_q <= S_DIV;
               end
            end

            // Restoring division, MSB of the fraction first. The quotient
            // is built in quot_q and copied to the output register only when
            // complete so alpha_ff_din never shows a partial result.
            S_DIV: begin
               quot_q <= w_quot_upd;
               if (w_ge) begin
                  rem_q <= (SM_SUM_DATA_WIDTH+1)'(w_shift - w_sum_sh);
               end else begin
                  rem_q <= w_shift[SM_SUM_DATA_WIDTH:0];
               end
               if (bit_q == '0) begin
                  alpha_q <= w_quot_upd;
                  state_q <= S_PUSH;
               end else begin
                  bit_q <= bit_q - 1'b1;
               end
            end

            S_PUSH: begin
               if (alpha_ff_wr_vld) begin
                  cnt_q   <= cnt_q + 1'b1;
                  state_q <= w_last ? S_IDLE : S_FETCH;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
